// File: rtl/alu_op_sequencer.sv
// Operand/issue sequencer in front of a combinational ALU: register-file read, registered ALU drive,
// result capture with writeback and flags. Define ALU_OP_SEQ_R0_ZERO_EN to hard-wire register 0 to zero.
//
// state | meaning
// IDLE  | instr_ready high, waiting for an instruction
// READ  | operands read from the register file into alu_a/alu_b/alu_sel
// EXEC  | ALU inputs stable; result captured, written back, flags updated
// RESP  | res_valid high until res_ready

module alu_op_sequencer #(
   parameter int WIDTH = 4,
   parameter int NREGS = 4,
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_rs1,
   input  logic [AW-1:0]    instr_rs2,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_z,
   output logic             flag_c,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

`ifdef ALU_OP_SEQ_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state, state_next;

   logic [2:0]       op_q;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    rs1_q;
   logic [AW-1:0]    rs2_q;
   logic [WIDTH-1:0] rf [NREGS];

   logic             accept;
   logic             read_fire;
   logic             exec_fire;
   logic             resp_done;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] opnd_b;
   logic             wr_allowed;
   logic             wb_allowed;

   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      read_fire   = 1'b0;
      exec_fire   = 1'b0;
      resp_done   = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               accept     = 1'b1;
               state_next = READ;
            end
         end
         READ: begin
            read_fire  = 1'b1;
            state_next = EXEC;
         end
         EXEC: begin
            exec_fire  = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            if (res_ready) begin
               resp_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Register 0 optionally reads as zero and ignores every write
   assign opnd_a     = (R0_ZERO && rs1_q == '0) ? '0 : rf[rs1_q];
   assign opnd_b     = (R0_ZERO && rs2_q == '0) ? '0 : rf[rs2_q];
   assign dbg_data   = (R0_ZERO && dbg_addr == '0) ? '0 : rf[dbg_addr];
   assign wr_allowed = !(R0_ZERO && wr_addr == '0);
   assign wb_allowed = !(R0_ZERO && rd_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
         end
         if (read_fire) begin
            alu_a   <= opnd_a;
            alu_b   <= opnd_b;
            alu_sel <= op_q;
         end
         if (exec_fire) begin
            res_data  <= alu_result;
            flag_z    <= (alu_result == '0);
            res_valid <= 1'b1;
            if (op_q == OP_ADD || op_q == OP_SUB) flag_c <= alu_carry;
         end else if (resp_done) begin
            res_valid <= 1'b0;
         end
         if (wr_en && wr_allowed) rf[wr_addr] <= wr_data;
         // Later assignment: writeback wins over a same-cycle external write
         if (exec_fire && wb_allowed) rf[rd_q] <= alu_result;
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle operand/issue stage that sits directly upstream of the 4-bit combinational ALU. It accepts 3-operand instructions over a valid/ready handshake, reads operands from a small internal register file, and drives the ALU's A/B/sel inputs from registers. It captures the ALU result and carry, writes the result back to the destination register, updates the zero/carry flags, and presents the result on an output valid/ready handshake.

Parameters:
WIDTH, 4, datapath width; must match the ALU operand width.
NREGS, 4, register file depth; register address width AW = $clog2(NREGS) (2 at default).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE
instr_op  in  3  ALU select code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A>B, 111 A==B
instr_rd  in  AW  destination register
instr_rs1  in  AW  source of ALU A
instr_rs2  in  AW  source of ALU B
wr_en  in  1  external register-file load
wr_addr  in  AW  external load address
wr_data  in  WIDTH  external load data
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_sel  out  3  registered select to ALU
alu_result  in  WIDTH  ALU result
alu_carry  in  1  ALU carry/borrow
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  WIDTH  captured result
flag_z  out  1  last result == 0
flag_c  out  1  carry from last add/sub
dbg_addr  in  AW  debug read address
dbg_data  out  WIDTH  combinational rf[dbg_addr]

Behaviour:
- Reset (synchronous, clk edge with rst=1): state=IDLE; all registers, alu_a, alu_b, alu_sel, res_data, flag_z, flag_c = 0; res_valid=0; instr_ready=1 in the following cycle. Reset aborts any in-flight instruction; no writeback occurs.
- FSM states IDLE -> READ -> EXEC -> RESP -> IDLE.
- IDLE: instr_ready=1. On instr_valid at the edge, latch op/rd/rs1/rs2 and go to READ; otherwise stay in IDLE.
- READ (T+1): alu_a <= rf[rs1], alu_b <= rf[rs2], alu_sel <= op. Go to EXEC.
- EXEC (T+2): the ALU inputs are stable for the whole cycle. At the edge: res_data <= alu_result; rf[rd] <= alu_result; flag_z <= (alu_result == 0); flag_c <= alu_carry for ops 000/001 only, held otherwise; res_valid <= 1. Go to RESP.
- RESP: res_valid=1, and res_data/flags are held stable until res_ready=1 at an edge. Then res_valid <= 0 and the FSM returns to IDLE. Minimum period per instruction is 4 cycles (res_ready tied high).
- alu_a/alu_b/alu_sel hold their last values outside READ/EXEC; they do not return to zero.
- External write: wr_en writes rf[wr_addr] in any state. If it collides with the EXEC writeback to the same address in the same cycle, the writeback wins. An external write in the READ cycle is not forwarded: READ sees the pre-edge contents.
- rd may equal rs1/rs2: the operands were already latched in READ, so the writeback is safe.
- instr_valid outside IDLE is ignored (not accepted, not queued).
- All arithmetic is modulo 2^WIDTH; the sequencer does not interpret the result.
- dbg_data is a purely combinational read that reflects contents after the last edge.

Optional Feature:
ALU_OP_SEQ_R0_ZERO_EN:
- Defined: register 0 reads as 0 (READ operands and dbg_data); writebacks and external writes to address 0 are discarded. res_data and flags still reflect the computed result.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then wr r1=1101, r2=1011; issue add rd=3,rs1=1,rs2=2 with res_ready=1 -> accepted at T, alu_sel=000 visible at T+2, res_valid at T+3, res_data=1000, flag_c=1, flag_z=0, dbg r3=1000; instr_ready high again at T+4.
- r1=1100, r2=1010; issue xor rd=0 then and rd=1 back-to-back -> second instr not accepted until IDLE; r0=0110, r1=1000; flag_c unchanged from the prior add.
- Hold res_ready=0 for 5 cycles after res_valid -> res_valid/res_data stable, instr_ready=0 throughout; accept on the first res_ready edge.
- In EXEC, wr_en to rd with 1111 and alu_result=0000 (eq op, A!=B) -> rf[rd]=0000, flag_z=1.
- Assert rst in EXEC -> next cycle res_valid=0, all rf=0, flags=0, instr_ready=1, rd not written.
- With ALU_OP_SEQ_R0_ZERO_EN: wr r0=0101, then sub rd=0,rs1=0,rs2=1 (r1=0001) -> res_data=1111, flag_c=1, dbg r0=0000.
